// File: rtl/deal_pkg.sv
// Shared types, constants and helpers for the blackjack round sequencer.
package deal_pkg;

  localparam int DECK_SIZE_DEF    = 52;
  localparam int DEALER_STAND_DEF = 17;
  localparam int BJ_LIMIT_DEF     = 21;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PLAYER  = 3'd3,
    ST_DEALER  = 3'd4,
    ST_RESULT  = 3'd5
  } state_e;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  // Rank to hard value: ace counts 1, face cards count 10.
  function automatic logic [4:0] card_value(input logic [3:0] rank);
    if (rank >= 4'd10) return 5'd10;
    else               return {1'b0, rank};
  endfunction

endpackage

// File: rtl/deal_ctrl_hand_acc.sv
// One hand: hard sum (ace = 1) plus an ace flag, giving the best total.
module hand_acc
  import deal_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add_en,
  input  logic [3:0] rank,
  output logic [4:0] hard,
  output logic [4:0] best
);

  logic [4:0] hard_q, hard_d;
  logic       has_ace_q, has_ace_d;
  logic [5:0] sum;

  // Next hand contents: clear wins over add; the sum saturates at 31.
  always_comb begin
    sum       = {1'b0, hard_q} + {1'b0, card_value(rank)};
    hard_d    = hard_q;
    has_ace_d = has_ace_q;
    if (clear) begin
      hard_d    = 5'd0;
      has_ace_d = 1'b0;
    end else if (add_en) begin
      hard_d    = (sum > 6'd31) ? 5'd31 : sum[4:0];
      has_ace_d = has_ace_q | (rank == 4'd1);
    end
  end

  // Hand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hard_q    <= 5'd0;
      has_ace_q <= 1'b0;
    end else begin
      hard_q    <= hard_d;
      has_ace_q <= has_ace_d;
    end
  end

  // One ace may count 11 when that does not bust the hand.
  always_comb begin
    hard = hard_q;
    best = (has_ace_q && (hard_q <= 5'd11)) ? hard_q + 5'd10 : hard_q;
  end

endmodule

// File: rtl/deal_ctrl.sv
// Blackjack round sequencer: deals from the card LUT, serves the player,
// plays the dealer hand and reports the round result.
//
// LUT handshake: pip is a one-cycle draw request with no backpressure; the
// LUT returns the drawn rank on `number` exactly one cycle later (CAPTURE).
module deal_ctrl
  import deal_pkg::*;
#(
  parameter int DECK_SIZE    = DECK_SIZE_DEF,
  parameter int DEALER_STAND = DEALER_STAND_DEF,
  parameter int BJ_LIMIT     = BJ_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  output logic       pip,
  input  logic [3:0] number,
  output logic [4:0] player_pts,
  output logic [4:0] dealer_pts,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic       deck_empty,
  output logic [5:0] cards_used,
  output state_e     dbg_state
);

  state_e     state_q, state_d;
  logic       dealing_q, dealing_d;     // opening four-card deal in progress
  logic [1:0] deal_cnt_q, deal_cnt_d;   // opening card index 0..3
  logic       to_dealer_q, to_dealer_d; // target hand of the current draw
  logic [1:0] result_q, result_d;
  logic       deck_empty_q, deck_empty_d;
  logic [5:0] cards_used_q, cards_used_d;

  logic       clear_hands, p_add, d_add;
  logic [4:0] p_hard, p_best, d_hard, d_best;
  logic [5:0] p_next_hard;
  logic       deck_out;

  hand_acc u_player (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_hands),
    .add_en (p_add),
    .rank   (number),
    .hard   (p_hard),
    .best   (p_best)
  );

  hand_acc u_dealer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_hands),
    .add_en (d_add),
    .rank   (number),
    .hard   (d_hard),
    .best   (d_best)
  );

  assign deck_out    = (cards_used_q == 6'(DECK_SIZE));
  assign p_next_hard = {1'b0, p_hard} + {1'b0, card_value(number)};

  // State and round bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dealing_q    <= 1'b0;
      deal_cnt_q   <= 2'd0;
      to_dealer_q  <= 1'b0;
      result_q     <= RES_NONE;
      deck_empty_q <= 1'b0;
      cards_used_q <= 6'd0;
    end else begin
      state_q      <= state_d;
      dealing_q    <= dealing_d;
      deal_cnt_q   <= deal_cnt_d;
      to_dealer_q  <= to_dealer_d;
      result_q     <= result_d;
      deck_empty_q <= deck_empty_d;
      cards_used_q <= cards_used_d;
    end
  end

  // Next-state and bookkeeping updates for the round sequence.
  always_comb begin
    state_d      = state_q;
    dealing_d    = dealing_q;
    deal_cnt_d   = deal_cnt_q;
    to_dealer_d  = to_dealer_q;
    result_d     = result_q;
    deck_empty_d = deck_empty_q;
    cards_used_d = cards_used_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !deck_empty_q) begin
          result_d    = RES_NONE;
          dealing_d   = 1'b1;
          deal_cnt_d  = 2'd0;
          to_dealer_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // An exhausted deck aborts the round instead of reading past the end.
        if (deck_out) begin
          deck_empty_d = 1'b1;
          result_d     = RES_NONE;
          dealing_d    = 1'b0;
          state_d      = ST_RESULT;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        cards_used_d = cards_used_q + 6'd1;
        if (dealing_q) begin
          if (deal_cnt_q == 2'd3) begin
            dealing_d = 1'b0;
            state_d   = ST_PLAYER;
          end else begin
            deal_cnt_d  = deal_cnt_q + 2'd1;
            to_dealer_d = ~to_dealer_q;
            state_d     = ST_FETCH;
          end
        end else if (!to_dealer_q) begin
          // Player bust ends the round at once; the dealer does not draw.
          if (p_next_hard > 6'(BJ_LIMIT)) begin
            result_d = RES_DEALER;
            state_d  = ST_RESULT;
          end else begin
            state_d = ST_PLAYER;
          end
        end else begin
          state_d = ST_DEALER;
        end
      end
      ST_PLAYER: begin
        // Stand beats hit when both are asserted together.
        if (stand || (p_best == 5'(BJ_LIMIT))) begin
          state_d = ST_DEALER;
        end else if (hit) begin
          to_dealer_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end
      ST_DEALER: begin
        if (d_best < 5'(DEALER_STAND)) begin
          to_dealer_d = 1'b1;
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_RESULT;
          if (p_best > 5'(BJ_LIMIT))      result_d = RES_DEALER;
          else if (d_hard > 5'(BJ_LIMIT)) result_d = RES_PLAYER;
          else if (p_best > d_best)       result_d = RES_PLAYER;
          else if (p_best < d_best)       result_d = RES_DEALER;
          else                            result_d = RES_PUSH;
        end
      end
      ST_RESULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs and hand control strobes decoded from the current state.
  always_comb begin
    pip         = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    clear_hands = 1'b0;
    p_add       = 1'b0;
    d_add       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy        = 1'b0;
        clear_hands = start && !deck_empty_q;
      end
      ST_FETCH: begin
        pip = !deck_out;
      end
      ST_CAPTURE: begin
        p_add = !to_dealer_q;
        d_add = to_dealer_q;
      end
      ST_RESULT: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign player_pts = p_best;
  assign dealer_pts = d_best;
  assign result     = result_q;
  assign deck_empty = deck_empty_q;
  assign cards_used = cards_used_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_deal_ctrl.sv
// Bench for deal_ctrl: card LUT model, table of rounds, plus hand-written
// sequences for deal timing, deck exhaustion and reset during a draw.
module tb_deal_ctrl;
  import deal_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst, start, hit, stand;
  logic       pip;
  logic [3:0] number;
  logic [4:0] player_pts, dealer_pts;
  logic       busy, done, deck_empty;
  logic [1:0] result;
  logic [5:0] cards_used;
  state_e     dbg_state;

  always #5 clk = ~clk;

  deal_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hit        (hit),
    .stand      (stand),
    .pip        (pip),
    .number     (number),
    .player_pts (player_pts),
    .dealer_pts (dealer_pts),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .deck_empty (deck_empty),
    .cards_used (cards_used),
    .dbg_state  (dbg_state)
  );

  // ---------------- card LUT model (reset together with the DUT) ----------------
  logic [3:0] rom [52];
  logic [5:0] lut_ptr;
  int         n_pip;
  int         n_pip_empty = 0;

  always @(posedge clk) begin
    if (rst) begin
      lut_ptr <= 6'd0;
      number  <= 4'd0;
      n_pip   <= 0;
    end else if (pip) begin
      number  <= rom[lut_ptr];
      lut_ptr <= lut_ptr + 6'd1;
      n_pip   <= n_pip + 1;
      if (cards_used == 6'd52) n_pip_empty <= n_pip_empty + 1;
    end
  end

  int deck_a [17] = '{10, 5, 8, 7, 10, 2, 7, 11, 6, 5, 1, 4, 13, 10, 11, 13, 6};
  int deck_b [9]  = '{13, 10, 11, 13, 9, 6, 9, 5, 8};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_deck(input bit use_b);
    for (int i = 0; i < 52; i++) begin
      if (use_b) rom[i] = (i < 9)  ? 4'(deck_b[i]) : 4'd10;
      else       rom[i] = (i < 17) ? 4'(deck_a[i]) : 4'd10;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pip"},        pip,        0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_done"},       done,       0);
    chk({tag, "_result"},     result,     0);
    chk({tag, "_player_pts"}, player_pts, 0);
    chk({tag, "_dealer_pts"}, dealer_pts, 0);
    chk({tag, "_cards_used"}, cards_used, 0);
    chk({tag, "_deck_empty"}, deck_empty, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; hit = 1'b0; stand = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for the FSM to show a given state.
  task automatic wait_state(input state_e s, input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dbg_state == s) break;
    end
    chk({name, "_reached"}, int'(k < 200), 1);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_done_seen"}, int'(k < 200), 1);
  endtask

  // Wait (bounded) for a hit to finish: back in PLAYER, or round over.
  task automatic wait_hit(input string name, output bit ended);
    int k;
    ended = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin ended = 1'b1; break; end
      if (dbg_state == ST_PLAYER) break;
    end
    chk({name, "_hit_back"}, int'(k < 200), 1);
  endtask

  // ---------------- round table ----------------
  typedef struct {
    bit reset_first;
    bit use_b;
    bit timed;
    int hits;
    bit both;
    int p0, d0;
    int res, pf, df, used;
  } row_t;

  row_t rows [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    ended;
    string tag;

    //            rst b  tm hit bo  p0  d0 res  pf  df used
    rows[0] = '{1, 0, 1, 0, 0, 18, 12, 1, 18, 22,  5};
    rows[1] = '{0, 0, 0, 2, 0, 12, 13, 1, 18, 17, 12};
    rows[2] = '{0, 0, 0, 1, 0, 20, 20, 2, 26, 20, 17};
    rows[3] = '{1, 1, 0, 0, 0, 20, 20, 3, 20, 20,  4};
    rows[4] = '{0, 1, 0, 0, 1, 18, 11, 2, 18, 19,  9};
    for (int i = 5; i < 15; i++) rows[i] = '{0, 1, 0, 0, 0, 20, 20, 3, 20, 20, 9 + 4 * (i - 4)};

    rst = 1'b1; start = 1'b0; hit = 1'b0; stand = 1'b0;

    for (int r = 0; r < 15; r++) begin
      tag = $sformatf("r%0d", r);
      if (rows[r].reset_first) begin
        load_deck(rows[r].use_b);
        do_reset();
      end

      // Opening deal
      if (rows[r].timed) begin
        @(posedge clk);
        #1 start = 1'b1;                 // cycle 0
        @(posedge clk);
        #1 start = 1'b0;                 // cycle 1
        for (int c = 1; c <= 9; c++) begin
          @(negedge clk);
          if (c < 9) chk($sformatf("%s_pip_c%0d", tag, c), pip, c % 2);
          else       chk({tag, "_player_at_c9"}, int'(dbg_state), int'(ST_PLAYER));
        end
      end else begin
        pulse_start();
        wait_state(ST_PLAYER, tag);
      end
      chk({tag, "_deal_player"}, player_pts, rows[r].p0);
      chk({tag, "_deal_dealer"}, dealer_pts, rows[r].d0);

      // Player turn
      ended = 1'b0;
      for (int h = 0; h < rows[r].hits && !ended; h++) begin
        hit = 1'b1;
        @(posedge clk);
        #1 hit = 1'b0;
        wait_hit(tag, ended);
      end
      if (!ended) begin
        stand = 1'b1;
        hit   = rows[r].both;
        @(posedge clk);
        #1 stand = 1'b0; hit = 1'b0;
        if (rows[r].both) begin
          @(negedge clk);
          chk({tag, "_both_to_dealer"}, int'(dbg_state), int'(ST_DEALER));
          chk({tag, "_both_no_pip"},    pip, 0);
          pulse_start();                 // start while busy: must be ignored
        end
        wait_done(tag);
      end

      chk({tag, "_result"},     result,     rows[r].res);
      chk({tag, "_player_pts"}, player_pts, rows[r].pf);
      chk({tag, "_dealer_pts"}, dealer_pts, rows[r].df);
      chk({tag, "_cards_used"}, cards_used, rows[r].used);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 0);
      chk({tag, "_idle_after"},     busy, 0);
      chk({tag, "_result_hold"},    result, rows[r].res);
    end

    // Deck exhaustion: three cards remain, the fourth draw finds none.
    pulse_start();
    wait_done("empty");
    chk("empty_result",     result,     0);
    chk("empty_flag",       deck_empty, 1);
    chk("empty_cards_used", cards_used, 52);
    chk("empty_player_pts", player_pts, 20);
    chk("empty_dealer_pts", dealer_pts, 10);
    chk("empty_pip_count",  n_pip,      52);
    chk("empty_pip_at_52",  n_pip_empty, 0);
    @(negedge clk);
    pulse_start();                       // ignored while deck_empty
    repeat (3) begin
      @(negedge clk);
      chk("empty_start_ignored", busy, 0);
    end
    chk("empty_sticky", deck_empty, 1);

    // Reset in the middle of a capture.
    load_deck(1'b1);
    do_reset();
    pulse_start();
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(negedge clk);
        if (dbg_state == ST_CAPTURE && cards_used == 6'd2) break;
      end
      chk("midcap_reached", int'(k < 50), 1);
    end
    chk("midcap_player_pts", player_pts, 10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("midcap");
    chk("midcap_state", int'(dbg_state), int'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
